if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end. It combines the program counter, the +4 sequencer and branch redirection with a DEPTH-entry prefetch queue in front of a handshaked instruction memory that can have variable latency. It sits between instruction memory and the IF/ID pipeline register. It delivers one {pc, inst} pair per cycle while the consumer is not frozen, and flushes on branch_taken.

---
 rtl/if_prefetch_unit.sv | 130 +++++++++++++
 tb/tb_if_prefetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: PC sequencer, branch redirect and a small
// prefetch queue in front of a handshaked, variable-latency instruction memory.
// At most one memory request is in flight; a redirect while a request is
// pending marks its response as stale so it is dropped on arrival.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_inst [DEPTH];

  logic              in_flight;
  logic              resolve;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_addr_bits;

  // Redirect targets are word-aligned; the low address bits are ignored.
  assign unused_addr_bits = ^branch_address[1:0];

  // Issue/push/pop decisions; occupancy counts the outstanding request so the
  // queue can never overflow, and pops of this cycle are deliberately not credited.
  always_comb begin
    in_flight = (state != ST_IDLE);
    resolve   = in_flight && imem_rvalid;
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, in_flight};
    credit_ok = (occupancy < DEPTH_C);
    issue     = !branch_taken && (!in_flight || imem_rvalid) && credit_ok;
    push      = resolve && (state == ST_WAIT) && !branch_taken;
    pop       = (count != CNT_ZERO) && !freeze && !branch_taken;
  end

  assign imem_req  = issue && !rst;
  assign imem_addr = fpc;
  assign out_valid = (count != CNT_ZERO);
  assign out_pc    = q_pc[rd_ptr];
  assign out_inst  = q_inst[rd_ptr];

  // Fetch FSM, PC sequencer and queue bookkeeping; a redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      fpc    <= RESET_PC;
      req_pc <= RESET_PC;
      count  <= CNT_ZERO;
      rd_ptr <= PTR_ZERO;
      wr_ptr <= PTR_ZERO;
    end else if (branch_taken) begin
      fpc    <= {branch_address[ADDR_W-1:2], 2'b00};
      count  <= CNT_ZERO;
      rd_ptr <= PTR_ZERO;
      wr_ptr <= PTR_ZERO;
      state  <= (in_flight && !imem_rvalid) ? ST_DISCARD : ST_IDLE;
    end else begin
      if (issue) begin
        fpc    <= fpc + PC_STEP;
        req_pc <= fpc;
        state  <= ST_WAIT;
      end else if (resolve) begin
        state  <= ST_IDLE;
      end else begin
        state  <= state;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents beyond the valid window are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: a variable-latency memory model
// answers the DUT's requests, and a queue-based reference model predicts the
// request stream and the head of the prefetch queue every cycle.
module tb_if_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  if_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model
  bit          mem_busy;
  int          mem_left;
  logic [31:0] mem_addr;
  int          lat_min = 1;
  int          lat_max = 1;

  // reference model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  int          m_pend;      // 0 none, 1 response kept, 2 response dropped
  logic [31:0] m_pend_pc;

  // observations of the most recent cycle
  bit          obs_req;
  logic [31:0] obs_addr;
  bit          obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] ra[$];
  logic [31:0] vp[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic step(input bit frz, input bit br, input logic [31:0] tgt);
    bit rv;
    bit exp_req;
    freeze         = frz;
    branch_taken   = br;
    branch_address = tgt;
    #3;
    rv      = imem_rvalid;
    exp_req = !br && (m_pend == 0 || rv) &&
              ((mq.size() + ((m_pend != 0) ? 1 : 0)) < DEPTH);
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = out_valid;
    obs_pc    = out_pc;
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_fpc);
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      check_eq("out_pc", out_pc, mq[0].pc);
      check_eq("out_inst", out_inst, mq[0].inst);
    end
    if (br) begin
      mq.delete();
      m_fpc  = {tgt[31:2], 2'b00};
      m_pend = (m_pend != 0 && !rv) ? 2 : 0;
    end else begin
      if (mq.size() != 0 && !frz) void'(mq.pop_front());
      if (rv && m_pend == 1) mq.push_back('{m_pend_pc, memword(m_pend_pc)});
      if (rv) m_pend = 0;
      if (exp_req) begin
        m_pend    = 1;
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_req) begin
      mem_busy = 1'b1;
      mem_left = $urandom_range(lat_max, lat_min);
      mem_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    if (mem_busy && mem_left > 0) mem_left--;
    imem_rvalid = mem_busy && (mem_left == 0);
    imem_rdata  = imem_rvalid ? memword(mem_addr) : $urandom();
  endtask

  // Runs n free-flowing cycles, collecting request addresses and output pcs.
  task automatic run_collect(input int n);
    ra.delete();
    vp.delete();
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_req) ra.push_back(obs_addr);
      if (obs_valid) vp.push_back(obs_pc);
    end
  endtask

  // Asynchronous reset between clock edges; entered and left at posedge+1.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    mq.delete();
    m_fpc       = 32'h0;
    m_pend      = 0;
    mem_busy    = 1'b0;
    mem_left    = 0;
    imem_rvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int guard;
    rst            = 1'b1;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = 32'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    mem_busy       = 1'b0;
    mem_left       = 0;
    mem_addr       = 32'h0;
    @(posedge clk);
    #1;
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_imem_req", {31'd0, imem_req}, 32'd0);

    // stream, latency 1: first output in cycle 2, one per cycle after
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check_eq("stream_c2_valid", {31'd0, obs_valid}, 32'd1);
    check_eq("stream_c2_pc", obs_pc, 32'h0);
    run_collect(10);
    check_eq("stream_len", vp.size(), 32'd10);
    for (int i = 0; i < vp.size(); i++) check_eq("stream_pc", vp[i], 32'(4 * (i + 1)));

    // backpressure: freeze from reset -> exactly DEPTH requests
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (obs_req) nreq++;
      check_eq("bp_hold_pc", obs_valid ? obs_pc : 32'h0, 32'h0);
    end
    check_eq("bp_reqs", nreq, 32'd4);
    run_collect(5);
    check_eq("bp_pops", vp.size(), 32'd5);
    for (int i = 0; i < vp.size(); i++) check_eq("bp_pop_pc", vp[i], 32'(4 * i));

    // branch with request outstanding, latency 3
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    guard = 0;
    while (!(mem_busy && !imem_rvalid) && guard < 10) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    check_eq("disc_setup", {31'd0, (mem_busy && !imem_rvalid)}, 32'd1);
    step(1'b0, 1'b1, 32'h203);
    run_collect(12);
    check_eq("disc_first_req", (ra.size() != 0) ? ra[0] : 32'hFFFF_FFFF, 32'h200);
    check_eq("disc_first_pc", (vp.size() != 0) ? vp[0] : 32'hFFFF_FFFF, 32'h200);

    // branch coincident with rvalid while frozen
    lat_min = 1; lat_max = 1;
    do_reset();
    guard = 0;
    while (!imem_rvalid && guard < 10) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    step(1'b0, 1'b0, 32'h0);
    check_eq("coin_setup", {31'd0, imem_rvalid}, 32'd1);
    step(1'b1, 1'b1, 32'h400);
    step(1'b1, 1'b0, 32'h0);
    check_eq("coin_valid", {31'd0, obs_valid}, 32'd0);
    check_eq("coin_req", {31'd0, obs_req}, 32'd1);
    check_eq("coin_addr", obs_addr, 32'h400);

    // reset mid-operation with three entries queued and a request pending
    do_reset();
    guard = 0;
    while (!(mq.size() == 3 && m_pend == 1) && guard < 12) begin
      step(1'b1, 1'b0, 32'h0);
      guard++;
    end
    check_eq("midrst_setup", mq.size(), 32'd3);
    do_reset();
    run_collect(4);
    check_eq("midrst_req", (ra.size() != 0) ? ra[0] : 32'hFFFF_FFFF, 32'h0);

    // PC wrap-around
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    run_collect(6);
    check_eq("wrap_nreq", {31'd0, (ra.size() >= 2)}, 32'd1);
    if (ra.size() >= 2) begin
      check_eq("wrap_req0", ra[0], 32'hFFFF_FFFC);
      check_eq("wrap_req1", ra[1], 32'h0);
    end
    check_eq("wrap_npc", {31'd0, (vp.size() >= 2)}, 32'd1);
    if (vp.size() >= 2) begin
      check_eq("wrap_pc0", vp[0], 32'hFFFF_FFFC);
      check_eq("wrap_pc1", vp[1], 32'h0);
    end

    // randomized traffic against the reference model
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(399, 0) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, $urandom());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
